snd_dma_addr: RTL and testbench
===============================

Name: snd_dma_addr

Overview:
- Sound DMA address stage that sits directly upstream of the MCU control block.
- Holds the CPU-programmed frame start/end registers and the play/repeat control bits.
- Runs the 21-bit current sound word address counter and drives snd[21:1], sft[21:1], sndon and sfrep into the control block.
- Consumes that block's word-load and frame-end strobes: the counter advances per fetched word and reloads or stops at frame end.

Parameters:
- AW, 21, width of word address (address bits 21:1).
- RST_CTRL, 2'b00, reset value of the {repeat, play} control bits.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- res  input  1  reset, synchronous, active-high.
- cs  input  1  register select, qualifies we/re.
- addr  input  4  register index (bus address bits 4:1).
- we  input  1  one-clk write strobe.
- re  input  1  one-clk read strobe.
- din  input  8  write data (odd byte lane).
- dout  output  8  read data, registered.
- sload  input  1  one-clk pulse; one sound word fetched.
- fend  input  1  one-clk pulse; counter reached frame end (snd == sft).
- snd  output  AW  current sound word address counter.
- sft  output  AW  active frame end address.
- sndon  output  1  play enable.
- sfrep  output  1  repeat enable.
- fstart  output  1  one-clk pulse each time a frame is (re)loaded.

Behaviour:
- Reset (res=1 at clk edge): all registers, snd, sft, shadows and dout = 0; {sfrep, sndon} = RST_CTRL; fstart = 0. Reset mid-frame aborts playback immediately.
- Register map (index to content):
  - 0: ctrl, bit0 = play, bit1 = repeat.
  - 1/2/3: start hi (bits 5:0 map to addr[21:16]) / mid [15:8] / lo [7:1]; din[0] ignored.
  - 4/5/6: counter hi/mid/lo, read-only.
  - 7/8/9: end hi/mid/lo, same packing as start.
  - 10-15: reads 0, writes ignored.
- Unused read bits return 0.
- Start/end writes go to shadow registers only. The active sft and the counter change only at frame load.
- Frame load, cycle after the trigger: snd <= start_shadow, sft <= end_shadow, fstart = 1 for one clk. Triggers:
  - ctrl write that takes play from 0 to 1;
  - fend while sndon=1 and sfrep=1.
- Writing play=1 while already playing: no reload. Repeat bit still updates.
- fend with sfrep=0: sndon cleared next clk, snd/sft hold.
- Writing play=0: sndon cleared next clk, counter holds.
- sload with sndon=1: snd <= snd+1, modulo 2^AW (0x1FFFFF wraps to 0). sload ignored when sndon=0.
- Priority in one clk: res > frame load (fend or play 0-to-1) > sload increment. A sload coinciding with fend is discarded.
- fend while sndon=0 is ignored.
- Read: dout valid the clk after re&cs. Counter bytes read live; no latching between byte reads. A read coinciding with a load returns the pre-load value.

Optional Feature:
- SND_CNT_WRITE_EN defined: indices 4/5/6 are writable. A write replaces the matching counter bits directly (takes effect next clk, beats sload that clk, loses to frame load).
- Undefined: counter registers are read-only and writes are ignored.

Decomposition:
- Shared package snd_pkg holds:
  - register index constants (SND_CTRL, SND_START_H/M/L, SND_CNT_H/M/L, SND_END_H/M/L);
  - ctrl bit positions;
  - AW default;
  - a typedef for the 21-bit word address.
- One natural sub-module, snd_addr_reg, is a byte-writable 21-bit address register (hi/mid/lo packing plus read mux). It is instantiated for start shadow and end shadow, and for the counter's write path when SND_CNT_WRITE_EN is defined.

Test Plan:
- Reset: program start=0x012340, end=0x012348, assert res -> all outputs 0, snd=0, sndon=0.
- Single frame: start=0x010000, end=0x010004, write ctrl=0x01 -> fstart pulse, snd=0x010000, sft=0x010004. 4 sload -> snd=0x010004. fend -> sndon=0 next clk, snd holds.
- Repeat with shadow update: ctrl=0x03, start=0x000100, end=0x000102. Mid-frame write end=0x000200. At fend -> snd=0x000100, sft=0x000200, fstart pulse, sndon stays 1.
- Simultaneous sload+fend in repeat -> snd=start exactly, no +1. Then sload alone -> start+1.
- Wrap: start=0x1FFFFE, end=0x000001, play. 3 sload -> snd = 0x1FFFFF, 0x000000, 0x000001.
- Readback: snd=0x0ABCDE -> reads at index 4/5/6 give 0x0A, 0xBC, 0xDE (lo shows address bits 7:1 in din[7:1]), one clk after re. With SND_CNT_WRITE_EN, write index 6 = 0x20 -> snd low bits 7:1 = 0x10.

Source files
------------

// File: rtl/snd_pkg.sv
// Shared definitions for the sound DMA address stage: register map, ctrl bits,
// word-address type and the hi/mid/lo byte packing used for register reads.
package snd_pkg;

  localparam int unsigned SND_AW = 21;

  typedef logic [SND_AW-1:0] snd_addr_t;

  localparam logic [3:0] SND_CTRL    = 4'd0;
  localparam logic [3:0] SND_START_H = 4'd1;
  localparam logic [3:0] SND_START_M = 4'd2;
  localparam logic [3:0] SND_START_L = 4'd3;
  localparam logic [3:0] SND_CNT_H   = 4'd4;
  localparam logic [3:0] SND_CNT_M   = 4'd5;
  localparam logic [3:0] SND_CNT_L   = 4'd6;
  localparam logic [3:0] SND_END_H   = 4'd7;
  localparam logic [3:0] SND_END_M   = 4'd8;
  localparam logic [3:0] SND_END_L   = 4'd9;

  localparam int unsigned CTRL_PLAY = 0;
  localparam int unsigned CTRL_REP  = 1;

  // Word address bit n holds bus address bit n+1: hi = addr[21:16], mid = addr[15:8],
  // lo = addr[7:1] presented in byte bits 7:1.
  function automatic logic [7:0] addr_byte(input snd_addr_t a, input logic [1:0] sel);
    logic [7:0] b;
    case (sel)
      2'd0:    b = {2'b00, a[20:15]};
      2'd1:    b = a[14:7];
      2'd2:    b = {a[6:0], 1'b0};
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/snd_addr_reg.sv
// Byte-writable word-address register with hi/mid/lo packing and byte read mux.
// Priority: ld_i > byte writes > inc_i.
module snd_addr_reg
  import snd_pkg::*;
#(
  parameter int unsigned AW = SND_AW
) (
  input  logic          clk_i,
  input  logic          res_i,
  input  logic          ld_i,
  input  logic [AW-1:0] ld_val_i,
  input  logic [2:0]    wr_i,
  input  logic [7:0]    din_i,
  input  logic          inc_i,
  input  logic [1:0]    rd_sel_i,
  output logic [AW-1:0] q_o,
  output logic [7:0]    rd_o
);

  logic [AW-1:0] q_q, q_d;
  snd_addr_t     merged;

  always_comb begin
    merged = snd_addr_t'(q_q);
    if (wr_i[2]) merged[20:15] = din_i[5:0];
    if (wr_i[1]) merged[14:7]  = din_i;
    if (wr_i[0]) merged[6:0]   = din_i[7:1];
    q_d = q_q;
    if (ld_i) begin
      q_d = ld_val_i;
    end else if (|wr_i) begin
      q_d = AW'(merged);
    end else if (inc_i) begin
      q_d = q_q + AW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o  = q_q;
  assign rd_o = addr_byte(snd_addr_t'(q_q), rd_sel_i);

endmodule

// File: rtl/snd_dma_addr.sv
// Sound DMA address stage: frame start/end shadows, play/repeat control and the
// word counter. Define SND_CNT_WRITE_EN to make counter indices 4/5/6 writable.
module snd_dma_addr
  import snd_pkg::*;
#(
  parameter int unsigned AW       = SND_AW,
  parameter logic [1:0]  RST_CTRL = 2'b00
) (
  input  logic          clk_i,
  input  logic          res_i,
  input  logic          cs_i,
  input  logic [3:0]    addr_i,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [7:0]    din_i,
  output logic [7:0]    dout_o,
  input  logic          sload_i,
  input  logic          fend_i,
  output logic [AW-1:0] snd_o,
  output logic [AW-1:0] sft_o,
  output logic          sndon_o,
  output logic          sfrep_o,
  output logic          fstart_o
);

  logic          wr_en, rd_en, ctrl_wr;
  logic [2:0]    start_wr, end_wr;
  logic [1:0]    start_sel, cnt_sel, end_sel;
  logic          play_q, play_d, rep_q, rep_d, fstart_q;
  logic          frame_ld, cnt_inc;
  logic [AW-1:0] start_q, end_q, snd_q, sft_q;
  logic [7:0]    start_rd, end_rd, cnt_rd, dout_q, dout_d;

  assign wr_en     = cs_i & we_i;
  assign rd_en     = cs_i & re_i;
  assign ctrl_wr   = wr_en && (addr_i == SND_CTRL);
  assign start_wr  = {wr_en && (addr_i == SND_START_H), wr_en && (addr_i == SND_START_M),
                      wr_en && (addr_i == SND_START_L)};
  assign end_wr    = {wr_en && (addr_i == SND_END_H), wr_en && (addr_i == SND_END_M),
                      wr_en && (addr_i == SND_END_L)};
  assign start_sel = 2'(addr_i - SND_START_H);
  assign cnt_sel   = 2'(addr_i - SND_CNT_H);
  assign end_sel   = 2'(addr_i - SND_END_H);

  always_comb begin
    frame_ld = (ctrl_wr && din_i[CTRL_PLAY] && !play_q) || (fend_i && play_q && rep_q);
    // A word fetch coinciding with frame end is dropped whether or not we repeat.
    cnt_inc  = sload_i && play_q && !fend_i;
    play_d   = play_q;
    rep_d    = rep_q;
    if (fend_i && play_q && !rep_q) play_d = 1'b0;
    if (ctrl_wr) begin
      play_d = din_i[CTRL_PLAY];
      rep_d  = din_i[CTRL_REP];
    end
  end

  snd_addr_reg #(.AW(AW)) u_start (
    .clk_i    (clk_i),
    .res_i    (res_i),
    .ld_i     (1'b0),
    .ld_val_i ('0),
    .wr_i     (start_wr),
    .din_i    (din_i),
    .inc_i    (1'b0),
    .rd_sel_i (start_sel),
    .q_o      (start_q),
    .rd_o     (start_rd)
  );

  snd_addr_reg #(.AW(AW)) u_end (
    .clk_i    (clk_i),
    .res_i    (res_i),
    .ld_i     (1'b0),
    .ld_val_i ('0),
    .wr_i     (end_wr),
    .din_i    (din_i),
    .inc_i    (1'b0),
    .rd_sel_i (end_sel),
    .q_o      (end_q),
    .rd_o     (end_rd)
  );

`ifdef SND_CNT_WRITE_EN
  logic [2:0] cnt_wr;
  assign cnt_wr = {wr_en && (addr_i == SND_CNT_H), wr_en && (addr_i == SND_CNT_M),
                   wr_en && (addr_i == SND_CNT_L)};

  snd_addr_reg #(.AW(AW)) u_cnt (
    .clk_i    (clk_i),
    .res_i    (res_i),
    .ld_i     (frame_ld),
    .ld_val_i (start_q),
    .wr_i     (cnt_wr),
    .din_i    (din_i),
    .inc_i    (cnt_inc),
    .rd_sel_i (cnt_sel),
    .q_o      (snd_q),
    .rd_o     (cnt_rd)
  );
`else
  always_ff @(posedge clk_i) begin
    if (res_i) begin
      snd_q <= '0;
    end else if (frame_ld) begin
      snd_q <= start_q;
    end else if (cnt_inc) begin
      snd_q <= snd_q + AW'(1);
    end
  end

  assign cnt_rd = addr_byte(snd_addr_t'(snd_q), cnt_sel);
`endif

  always_comb begin
    dout_d = dout_q;
    if (rd_en) begin
      case (addr_i)
        SND_CTRL:                         dout_d = {6'b000000, rep_q, play_q};
        SND_START_H, SND_START_M, SND_START_L: dout_d = start_rd;
        SND_CNT_H, SND_CNT_M, SND_CNT_L:  dout_d = cnt_rd;
        SND_END_H, SND_END_M, SND_END_L:  dout_d = end_rd;
        default:                          dout_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (res_i) begin
      {rep_q, play_q} <= RST_CTRL;
      fstart_q        <= 1'b0;
      sft_q           <= '0;
      dout_q          <= 8'h00;
    end else begin
      play_q   <= play_d;
      rep_q    <= rep_d;
      fstart_q <= frame_ld;
      dout_q   <= dout_d;
      if (frame_ld) sft_q <= end_q;
    end
  end

  assign snd_o    = snd_q;
  assign sft_o    = sft_q;
  assign sndon_o  = play_q;
  assign sfrep_o  = rep_q;
  assign fstart_o = fstart_q;
  assign dout_o   = dout_q;

endmodule

// File: tb/tb_snd_dma_addr.sv
// Directed self-checking bench for snd_dma_addr; honours SND_CNT_WRITE_EN.
module tb_snd_dma_addr;

  logic        clk = 1'b0;
  logic        res, cs, we, re, sload, fend;
  logic [3:0]  addr;
  logic [7:0]  din, dout;
  logic [20:0] snd, sft;
  logic        sndon, sfrep, fstart;

  int checks = 0;
  int errors = 0;

  snd_dma_addr dut (
    .clk_i    (clk),
    .res_i    (res),
    .cs_i     (cs),
    .addr_i   (addr),
    .we_i     (we),
    .re_i     (re),
    .din_i    (din),
    .dout_o   (dout),
    .sload_i  (sload),
    .fend_i   (fend),
    .snd_o    (snd),
    .sft_o    (sft),
    .sndon_o  (sndon),
    .sfrep_o  (sfrep),
    .fstart_o (fstart)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; din = d;
    step();
    cs = 1'b0; we = 1'b0;
  endtask

  // Word address w -> hi {2'b0,w[20:15]}, mid w[14:7], lo {w[6:0],0}.
  task automatic wr_addr(input logic [3:0] base, input logic [20:0] w);
    wr(base,        {2'b00, w[20:15]});
    wr(base + 4'd1, w[14:7]);
    wr(base + 4'd2, {w[6:0], 1'b0});
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] exp, input string tag);
    cs = 1'b1; re = 1'b1; addr = a;
    step();
    cs = 1'b0; re = 1'b0;
    chk(tag, {24'h0, dout}, {24'h0, exp});
  endtask

  task automatic pulse_sload();
    sload = 1'b1;
    step();
    sload = 1'b0;
  endtask

  task automatic pulse_fend();
    fend = 1'b1;
    step();
    fend = 1'b0;
  endtask

  initial begin
    res = 1'b1; cs = 1'b0; we = 1'b0; re = 1'b0; sload = 1'b0; fend = 1'b0;
    addr = 4'h0; din = 8'h00;
    step(); step();
    res = 1'b0;

    // Reset aborts a running frame and clears shadows
    wr_addr(4'd1, 21'h012340);
    wr_addr(4'd7, 21'h012348);
    wr(4'd0, 8'h01);
    chk("pre_rst_snd", {11'h0, snd}, 32'h012340);
    chk("pre_rst_sndon", {31'h0, sndon}, 32'h1);
    res = 1'b1;
    step();
    res = 1'b0;
    chk("rst_snd", {11'h0, snd}, 32'h0);
    chk("rst_sft", {11'h0, sft}, 32'h0);
    chk("rst_sndon", {31'h0, sndon}, 32'h0);
    chk("rst_sfrep", {31'h0, sfrep}, 32'h0);
    chk("rst_fstart", {31'h0, fstart}, 32'h0);
    chk("rst_dout", {24'h0, dout}, 32'h0);
    rd(4'd1, 8'h00, "rst_start_h");
    rd(4'd9, 8'h00, "rst_end_l");

    // Single frame
    wr_addr(4'd1, 21'h010000);
    wr_addr(4'd7, 21'h010004);
    chk("shadow_no_sft", {11'h0, sft}, 32'h0);
    wr(4'd0, 8'h01);
    chk("sf_fstart", {31'h0, fstart}, 32'h1);
    chk("sf_snd", {11'h0, snd}, 32'h010000);
    chk("sf_sft", {11'h0, sft}, 32'h010004);
    chk("sf_sndon", {31'h0, sndon}, 32'h1);
    step();
    chk("sf_fstart_low", {31'h0, fstart}, 32'h0);
    sload = 1'b1;
    repeat (4) step();
    sload = 1'b0;
    chk("sf_4load", {11'h0, snd}, 32'h010004);
    pulse_fend();
    chk("sf_end_sndon", {31'h0, sndon}, 32'h0);
    chk("sf_end_snd", {11'h0, snd}, 32'h010004);
    chk("sf_end_fstart", {31'h0, fstart}, 32'h0);
    pulse_sload();
    chk("sload_idle", {11'h0, snd}, 32'h010004);
    pulse_fend();
    chk("fend_idle", {11'h0, snd}, 32'h010004);

    // Repeat with mid-frame end update
    wr_addr(4'd1, 21'h000100);
    wr_addr(4'd7, 21'h000102);
    wr(4'd0, 8'h03);
    chk("rp_snd", {11'h0, snd}, 32'h000100);
    chk("rp_sft", {11'h0, sft}, 32'h000102);
    chk("rp_sfrep", {31'h0, sfrep}, 32'h1);
    pulse_sload();
    chk("rp_inc1", {11'h0, snd}, 32'h000101);
    wr_addr(4'd7, 21'h000200);
    chk("rp_sft_hold", {11'h0, sft}, 32'h000102);
    pulse_sload();
    chk("rp_inc2", {11'h0, snd}, 32'h000102);
    pulse_fend();
    chk("rp_reload_snd", {11'h0, snd}, 32'h000100);
    chk("rp_reload_sft", {11'h0, sft}, 32'h000200);
    chk("rp_reload_fstart", {31'h0, fstart}, 32'h1);
    chk("rp_reload_sndon", {31'h0, sndon}, 32'h1);

    // sload coinciding with fend is discarded
    sload = 1'b1; fend = 1'b1;
    step();
    sload = 1'b0; fend = 1'b0;
    chk("sim_snd", {11'h0, snd}, 32'h000100);
    pulse_sload();
    chk("sim_next", {11'h0, snd}, 32'h000101);
    wr(4'd0, 8'h03);
    chk("replay_no_fstart", {31'h0, fstart}, 32'h0);
    chk("replay_snd", {11'h0, snd}, 32'h000101);
    wr(4'd0, 8'h01);
    chk("rep_clr_sfrep", {31'h0, sfrep}, 32'h0);
    chk("rep_clr_sndon", {31'h0, sndon}, 32'h1);
    wr(4'd0, 8'h00);
    chk("stop_sndon", {31'h0, sndon}, 32'h0);
    chk("stop_snd", {11'h0, snd}, 32'h000101);

    // Counter wraps modulo 2^21
    wr_addr(4'd1, 21'h1FFFFE);
    wr_addr(4'd7, 21'h000001);
    wr(4'd0, 8'h01);
    chk("wr_start", {11'h0, snd}, 32'h1FFFFE);
    pulse_sload();
    chk("wrap1", {11'h0, snd}, 32'h1FFFFF);
    pulse_sload();
    chk("wrap2", {11'h0, snd}, 32'h000000);
    pulse_sload();
    chk("wrap3", {11'h0, snd}, 32'h000001);
    pulse_fend();
    chk("wrap_end", {31'h0, sndon}, 32'h0);

    // Readback of start bytes and live counter; lo byte bit 0 is dropped
    wr(4'd1, 8'h0A);
    wr(4'd2, 8'hBC);
    wr(4'd3, 8'hDF);
    wr(4'd0, 8'h01);
    chk("rb_snd", {11'h0, snd}, 32'h055E6F);
    rd(4'd4, 8'h0A, "rb_cnt_h");
    rd(4'd5, 8'hBC, "rb_cnt_m");
    rd(4'd6, 8'hDE, "rb_cnt_l");
    rd(4'd1, 8'h0A, "rb_start_h");
    rd(4'd3, 8'hDE, "rb_start_l");
    rd(4'd8, 8'h00, "rb_end_m");
    rd(4'd0, 8'h01, "rb_ctrl");
    rd(4'd12, 8'h00, "rb_unused");

    wr(4'd6, 8'h20);
`ifdef SND_CNT_WRITE_EN
    chk("cnt_write", {11'h0, snd}, 32'h055E10);
`else
    chk("cnt_write_ignored", {11'h0, snd}, 32'h055E6F);
`endif
    wr(4'd0, 8'h00);
    chk("final_stop", {31'h0, sndon}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
